// File: rtl/gate_test_sequencer_if.sv
// Bundle between the gate sequencer, the gate under test and the status block.
// GATE_SEQ_ERRLOG_EN adds the first-failure log signals.
interface gate_test_sequencer_if #(
    parameter int ERRW = 3
);
    logic            start;
    logic            abort;
    logic            gate_y;
    logic            gate_a;
    logic            gate_b;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ERRW-1:0] err_cnt;
    logic [1:0]      vec_idx;
`ifdef GATE_SEQ_ERRLOG_EN
    logic            fail_valid;
    logic [1:0]      fail_vec;
`endif

    modport master (
`ifdef GATE_SEQ_ERRLOG_EN
        output fail_valid,
        output fail_vec,
`endif
        input  start,
        input  abort,
        input  gate_y,
        output gate_a,
        output gate_b,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output vec_idx
    );

    modport slave (
`ifdef GATE_SEQ_ERRLOG_EN
        input  fail_valid,
        input  fail_vec,
`endif
        output start,
        output abort,
        output gate_y,
        input  gate_a,
        input  gate_b,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  vec_idx
    );
endinterface

// File: rtl/gate_test_sequencer.sv
// Sweeps a 2-input gate through 00,01,10,11 and checks y against TRUTH.
// GATE_SEQ_ERRLOG_EN adds fail_valid/fail_vec (first mismatching vector).
module gate_test_sequencer #(
    parameter int         SETTLE = 2,
    parameter logic [3:0] TRUTH  = 4'b0111,
    parameter int         ERRW   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_test_sequencer_if.master bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [ERRW-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;

    state_e          state_q, state_d;
    logic [1:0]      vec_q, vec_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ERRW-1:0] err_q, err_d;
    logic            gate_a_q, gate_a_d;
    logic            gate_b_q, gate_b_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            mismatch;
`ifdef GATE_SEQ_ERRLOG_EN
    logic            fail_valid_q, fail_valid_d;
    logic [1:0]      fail_vec_q, fail_vec_d;
`endif

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        pass_d   = pass_q;
        mismatch = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    vec_d   = 2'd0;
                    cnt_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SAMPLE: begin
                mismatch = (bus.gate_y != TRUTH[vec_q]);
                if (mismatch && err_q != ERR_MAX) begin
                    err_d = err_q + ERRW'(1);
                end
                if (vec_q == 2'd3) begin
                    state_d = DONE;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = DRIVE;
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
        // Abort freezes err/vec at their current values; a pending sample is dropped.
        if (bus.abort) begin
            state_d  = IDLE;
            vec_d    = vec_q;
            cnt_d    = cnt_q;
            err_d    = err_q;
            pass_d   = 1'b0;
            mismatch = 1'b0;
        end
        busy_d   = (state_d == DRIVE) || (state_d == SAMPLE);
        done_d   = (state_d == DONE);
        gate_a_d = busy_d & vec_d[1];
        gate_b_d = busy_d & vec_d[0];
    end

`ifdef GATE_SEQ_ERRLOG_EN
    always_comb begin
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        if (bus.abort || (state_q == IDLE && bus.start)) begin
            fail_valid_d = 1'b0;
            fail_vec_d   = 2'd0;
        end else if (mismatch && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= 2'd0;
            cnt_q        <= '0;
            err_q        <= '0;
            gate_a_q     <= 1'b0;
            gate_b_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef GATE_SEQ_ERRLOG_EN
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            gate_a_q     <= gate_a_d;
            gate_b_q     <= gate_b_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
`ifdef GATE_SEQ_ERRLOG_EN
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
`endif
        end
    end

    assign bus.gate_a  = gate_a_q;
    assign bus.gate_b  = gate_b_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;
    assign bus.vec_idx = vec_q;
`ifdef GATE_SEQ_ERRLOG_EN
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_vec   = fail_vec_q;
`endif

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomised scenario bench for gate_test_sequencer against a schedule model.
// Define GATE_SEQ_ERRLOG_EN to also check the first-failure log.
module tb_gate_test_sequencer;
    localparam int         SETTLE = 2;
    localparam logic [3:0] TRUTH  = 4'b0111;
    localparam int         EW     = 3;
    localparam int         P      = SETTLE + 1;
    localparam int         NSW    = 4 * P;

    logic clk;
    logic rst_n;
    logic [3:0] gate_tt;
    int n_checks;
    int n_errors;
    logic [EW-1:0] last_err;
    logic [1:0]    last_vec;

    gate_test_sequencer_if #(.ERRW(EW)) bus ();

    gate_test_sequencer #(
        .SETTLE (SETTLE),
        .TRUTH  (TRUTH),
        .ERRW   (EW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural gate under test: any truth table, faulty or not.
    assign bus.gate_y = gate_tt[{bus.gate_a, bus.gate_b}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mismatches from vectors whose sample cycle lies before cycle c.
    function automatic int errs_before(input logic [3:0] tt, input int c);
        int n;
        n = 0;
        for (int v = 0; v < 4; v++)
            if (P * v + P < c && tt[v] != TRUTH[v]) n++;
        if (n > (1 << EW) - 1) n = (1 << EW) - 1;
        return n;
    endfunction

    function automatic logic [2:0] fail_before(input logic [3:0] tt, input int c);
        for (int v = 0; v < 4; v++)
            if (P * v + P < c && tt[v] != TRUTH[v]) return {1'b1, 2'(v)};
        return 3'b000;
    endfunction

    function automatic logic [9:0] exp_pack(input logic [3:0] tt, input int c);
        logic [EW-1:0] e;
        logic [1:0] v;
        e = EW'(errs_before(tt, c));
        if (c <= NSW) begin
            v = 2'((c - 1) / P);
            return {1'b1, 1'b0, v[1], v[0], v, e, 1'b0};
        end
        return {1'b0, (c == NSW + 1), 1'b0, 1'b0, 2'd3, e, (e == '0)};
    endfunction

    function automatic logic [9:0] obs_pack();
        return {bus.busy, bus.done, bus.gate_a, bus.gate_b,
                bus.vec_idx, bus.err_cnt, bus.pass};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (obs_pack() !== 10'd0) begin
            n_errors++;
            $display("FAIL reset: got %b want %b", obs_pack(), 10'd0);
        end
`ifdef GATE_SEQ_ERRLOG_EN
        n_checks++;
        if ({bus.fail_valid, bus.fail_vec} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_log: got %b want 000", {bus.fail_valid, bus.fail_vec});
        end
`endif
        rst_n = 1'b1;
        last_err = '0;
        last_vec = 2'd0;
    endtask

    task automatic test_sweep(input logic [3:0] tt, input bit repulse, input string name);
        int ndone;
        logic [9:0] e;
        ndone = 0;
        gate_tt = tt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= NSW + 4; c++) begin
            e = exp_pack(tt, c);
            if (bus.done) ndone++;
            n_checks++;
            if (obs_pack() !== e) begin
                n_errors++;
                $display("FAIL %s cyc%0d: got %b want %b", name, c, obs_pack(), e);
            end
`ifdef GATE_SEQ_ERRLOG_EN
            n_checks++;
            if ({bus.fail_valid, bus.fail_vec} !== fail_before(tt, c)) begin
                n_errors++;
                $display("FAIL %s_log cyc%0d: got %b want %b", name, c,
                         {bus.fail_valid, bus.fail_vec}, fail_before(tt, c));
            end
`endif
            if (repulse && c <= NSW + 1)
                bus.start = (c == NSW + 1) ? 1'b1 : 1'($urandom_range(0, 1));
            else
                bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        n_checks++;
        if (ndone !== 1) begin
            n_errors++;
            $display("FAIL %s_done_count: got %0d want 1", name, ndone);
        end
        last_err = EW'(errs_before(tt, NSW + 1));
        last_vec = 2'd3;
    endtask

    task automatic test_abort(input int ac, input logic [3:0] tt);
        logic [9:0] e;
        int ndone;
        ndone = 0;
        gate_tt = tt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c < ac; c++) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        e = {4'b0000, 2'((ac - 1) / P), EW'(errs_before(tt, ac)), 1'b0};
        for (int k = 0; k < NSW + 2; k++) begin
            if (bus.done) ndone++;
            if (k < 3) begin
                n_checks++;
                if (obs_pack() !== e) begin
                    n_errors++;
                    $display("FAIL abort@%0d +%0d: got %b want %b", ac, k, obs_pack(), e);
                end
            end
            @(negedge clk);
        end
`ifdef GATE_SEQ_ERRLOG_EN
        n_checks++;
        if ({bus.fail_valid, bus.fail_vec} !== 3'b000) begin
            n_errors++;
            $display("FAIL abort_log: got %b want 000", {bus.fail_valid, bus.fail_vec});
        end
`endif
        n_checks++;
        if (ndone !== 0) begin
            n_errors++;
            $display("FAIL abort_no_done: got %0d want 0", ndone);
        end
        last_err = e[EW:1];
        last_vec = e[EW+2:EW+1];
    endtask

    task automatic test_start_abort_idle();
        logic [9:0] e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        e = {4'b0000, last_vec, last_err, 1'b0};
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_pack() !== e) begin
                n_errors++;
                $display("FAIL start_abort_idle +%0d: got %b want %b", k, obs_pack(), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid(input int rc);
        int ndone;
        ndone = 0;
        gate_tt = TRUTH;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c < rc; c++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (obs_pack() !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_mid@%0d: got %b want %b", rc, obs_pack(), 10'd0);
        end
        for (int k = 0; k < NSW + 2; k++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        n_checks++;
        if (ndone !== 0) begin
            n_errors++;
            $display("FAIL reset_mid_no_done: got %0d want 0", ndone);
        end
        last_err = '0;
        last_vec = 2'd0;
    endtask

    task automatic test_random();
        logic [3:0] tt;
        for (int i = 0; i < 8; i++) begin
            tt = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0)
                test_abort(int'($urandom_range(1, NSW)), tt);
            else
                test_sweep(tt, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        gate_tt   = TRUTH;
        test_reset();
        test_sweep(TRUTH, 1'b0, "nand");
        test_sweep(4'b1000, 1'b0, "and");
        test_sweep(4'b1111, 1'b0, "stuck1");
        test_abort(6, 4'b1000);
        test_sweep(TRUTH, 1'b0, "post_abort");
        test_sweep(4'b0110, 1'b1, "back_to_back");
        test_start_abort_idle();
        test_random();
        test_start_abort_idle();
        test_reset_mid(int'($urandom_range(1, NSW)));
        test_sweep(TRUTH, 1'b0, "post_reset");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
